// File: rtl/fx_pkg.sv
// Shared types, defaults and helpers for the stereo fx scheduler.
package fx_pkg;

    localparam int unsigned DW_DEF      = 24;
    localparam int unsigned TIMEOUT_DEF = 64;
    localparam int unsigned XF_LOG2_DEF = 6;

    typedef logic signed [DW_DEF-1:0] sample_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_L,
        S_WAIT_L,
        S_ISSUE_R,
        S_WAIT_R,
        S_EMIT
    } fx_state_t;

    // Width of a counter that must hold values 0..n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fx_xfade.sv
// Wet/dry crossfade mixer with per-frame k counter; only instantiated when
// FX_SCHED_SOFT_BYPASS_EN is defined.
module fx_xfade
    import fx_pkg::*;
#(
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned XF_LOG2 = XF_LOG2_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step_i,
    input  logic          bypass_new_i,
    input  logic          bypass_i,
    input  logic [DW-1:0] wet_l_i,
    input  logic [DW-1:0] wet_r_i,
    input  logic [DW-1:0] dry_l_i,
    input  logic [DW-1:0] dry_r_i,
    output logic          run_eng_c,
    output logic [DW-1:0] mix_l_c,
    output logic [DW-1:0] mix_r_c
);

    localparam int unsigned KW = XF_LOG2 + 1;
    localparam int unsigned MW = DW + XF_LOG2 + 1;
    localparam logic [KW-1:0] K_MAX = KW'(2 ** XF_LOG2);

    logic [KW-1:0] k_q;
    logic [KW-1:0] k_d;

    // k moves one step per frame toward 0 (dry) or K_MAX (wet).
    function automatic logic [KW-1:0] k_next(input logic [KW-1:0] k, input logic byp);
        if (byp && (k != '0)) begin
            return k - KW'(1);
        end
        if (!byp && (k != K_MAX)) begin
            return k + KW'(1);
        end
        return k;
    endfunction

    function automatic logic [DW-1:0] mix(input logic [DW-1:0] wet,
                                          input logic [DW-1:0] dry,
                                          input logic [KW-1:0] k);
        logic signed [MW-1:0] acc;
        acc = MW'($signed(wet)) * $signed(MW'(k))
            + MW'($signed(dry)) * $signed(MW'(K_MAX - k));
        return DW'(acc >>> XF_LOG2);
    endfunction

    // The frame in flight mixes with the k it will commit at EMIT.
    always_comb begin
        k_d       = k_next(k_q, bypass_i);
        run_eng_c = (k_next(k_q, bypass_new_i) != '0);
        mix_l_c   = mix(wet_l_i, dry_l_i, k_d);
        mix_r_c   = mix(wet_r_i, dry_r_i, k_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q <= K_MAX;
        end else if (step_i) begin
            k_q <= k_d;
        end
    end

endmodule

// File: rtl/fx_scheduler.sv
// Shares one mono engine between left/right channels per stereo frame.
// Optional soft bypass crossfade: define FX_SCHED_SOFT_BYPASS_EN.
module fx_scheduler
    import fx_pkg::*;
#(
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned XF_LOG2 = XF_LOG2_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_l,
    input  logic [DW-1:0] in_r,
    input  logic          bypass,
    output logic          eng_start,
    output logic [DW-1:0] eng_in,
    input  logic          eng_done,
    input  logic [DW-1:0] eng_out,
    output logic          out_valid,
    output logic [DW-1:0] out_l,
    output logic [DW-1:0] out_r,
    output logic          busy,
    output logic          overrun,
    output logic          timeout,
    input  logic          flag_clr
);

    localparam int unsigned   CW       = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    fx_state_t     state_q, state_d;
    logic [DW-1:0] dry_l_q, dry_l_d;
    logic [DW-1:0] dry_r_q, dry_r_d;
    logic [DW-1:0] wet_l_q, wet_l_d;
    logic [DW-1:0] wet_r_q, wet_r_d;
    logic          bypass_q, bypass_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          drop_q, drop_d;
    logic          eng_start_q, eng_start_d;
    logic [DW-1:0] eng_in_q, eng_in_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_l_q, out_l_d;
    logic [DW-1:0] out_r_q, out_r_d;
    logic          busy_q, busy_d;
    logic          overrun_q, overrun_d;
    logic          timeout_q, timeout_d;
    logic          done_ok_c;
    logic          run_eng_c;

`ifdef FX_SCHED_SOFT_BYPASS_EN
    logic [DW-1:0] mix_l_c;
    logic [DW-1:0] mix_r_c;
    logic          xf_step_c;

    assign xf_step_c = (state_q == S_EMIT);

    fx_xfade #(
        .DW      (DW),
        .XF_LOG2 (XF_LOG2)
    ) u_xfade (
        .clk          (clk),
        .rst          (rst),
        .step_i       (xf_step_c),
        .bypass_new_i (bypass),
        .bypass_i     (bypass_q),
        .wet_l_i      (wet_l_q),
        .wet_r_i      (wet_r_q),
        .dry_l_i      (dry_l_q),
        .dry_r_i      (dry_r_q),
        .run_eng_c    (run_eng_c),
        .mix_l_c      (mix_l_c),
        .mix_r_c      (mix_r_c)
    );
`else
    logic xf_unused;

    assign run_eng_c = !bypass;
    assign xf_unused = ^XF_LOG2;
`endif

    // A late done for a channel that already timed out must not be taken
    // as the answer for the next request.
    assign done_ok_c = eng_done && !drop_q;

    always_comb begin
        state_d     = state_q;
        dry_l_d     = dry_l_q;
        dry_r_d     = dry_r_q;
        wet_l_d     = wet_l_q;
        wet_r_d     = wet_r_q;
        bypass_d    = bypass_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        eng_start_d = 1'b0;
        eng_in_d    = eng_in_q;
        out_valid_d = 1'b0;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        busy_d      = busy_q;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;

        if (eng_done && drop_q) begin
            drop_d = 1'b0;
        end
        if (flag_clr) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end
        if (in_valid && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dry_l_d  = in_l;
                    dry_r_d  = in_r;
                    bypass_d = bypass;
                    busy_d   = 1'b1;
                    drop_d   = 1'b0;
                    if (run_eng_c) begin
                        state_d     = S_ISSUE_L;
                        eng_start_d = 1'b1;
                        eng_in_d    = in_l;
                    end else begin
                        state_d = S_EMIT;
                    end
                end
            end
            S_ISSUE_L: begin
                state_d = S_WAIT_L;
                cnt_d   = '0;
            end
            S_WAIT_L: begin
                if (done_ok_c || (cnt_q == CNT_LAST)) begin
                    if (done_ok_c) begin
                        wet_l_d = eng_out;
                    end else begin
                        wet_l_d   = dry_l_q;
                        timeout_d = 1'b1;
                        drop_d    = 1'b1;
                    end
                    state_d     = S_ISSUE_R;
                    eng_start_d = 1'b1;
                    eng_in_d    = dry_r_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ISSUE_R: begin
                state_d = S_WAIT_R;
                cnt_d   = '0;
            end
            S_WAIT_R: begin
                if (done_ok_c || (cnt_q == CNT_LAST)) begin
                    if (done_ok_c) begin
                        wet_r_d = eng_out;
                    end else begin
                        wet_r_d   = dry_r_q;
                        timeout_d = 1'b1;
                        drop_d    = 1'b1;
                    end
                    state_d = S_EMIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_EMIT: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
`ifdef FX_SCHED_SOFT_BYPASS_EN
                out_l_d     = mix_l_c;
                out_r_d     = mix_r_c;
`else
                out_l_d     = bypass_q ? dry_l_q : wet_l_q;
                out_r_d     = bypass_q ? dry_r_q : wet_r_q;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            dry_l_q     <= '0;
            dry_r_q     <= '0;
            wet_l_q     <= '0;
            wet_r_q     <= '0;
            bypass_q    <= 1'b0;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
            eng_start_q <= 1'b0;
            eng_in_q    <= '0;
            out_valid_q <= 1'b0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dry_l_q     <= dry_l_d;
            dry_r_q     <= dry_r_d;
            wet_l_q     <= wet_l_d;
            wet_r_q     <= wet_r_d;
            bypass_q    <= bypass_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            eng_start_q <= eng_start_d;
            eng_in_q    <= eng_in_d;
            out_valid_q <= out_valid_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    assign eng_start = eng_start_q;
    assign eng_in    = eng_in_q;
    assign out_valid = out_valid_q;
    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign timeout   = timeout_q;

endmodule
